mp3_sdi_feeder: RTL
===================

# mp3_sdi_feeder

Drains MP3 bytes from the stream FIFO and shifts them serially into the external decoder's SDI port (SCLK/MOSI/XDCS), paced by the decoder's DREQ. Sits directly downstream of the FIFO controller and its register file. It pops one byte per transfer and sends bursts of at most BURST_LEN bytes while the decoder signals room.

## Interface
- DATA_WIDTH, 8: FIFO word / SDI byte width
- CLK_DIV, 4: clk cycles per SCLK half-period (≥1)
- BURST_LEN, 32: max bytes per DREQ-qualified burst (≥1)

- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-high (port name kept per codebase)
- enable  in  1  playback enable; gates burst start and continuation
- fifo_empty  in  1  FIFO empty flag
- fifo_rdata  in  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
- fifo_rd  out  1  one-cycle pop strobe
- dreq  in  1  decoder data request, asynchronous
- sclk  out  1  SDI serial clock, idle low
- mosi  out  1  SDI data, MSB first
- xdcs  out  1  SDI chip select, active low
- busy  out  1  high whenever state ≠ IDLE
- burst_done  out  1  one-cycle pulse on every burst end

## Operation
- dreq passes through 2-FF synchronizer → dreq_s. No other CDC.
- FSM states: IDLE, LOAD, SHIFT, END.
- IDLE: xdcs=1, sclk=0. Go to LOAD when enable & dreq_s & ~fifo_empty. Clear burst_cnt.
- LOAD (1 cycle):
  - fifo_rd=1
  - shift_reg ← fifo_rdata
  - bit_cnt ← DATA_WIDTH-1, div_cnt ← 0
  - xdcs=0
  - next state SHIFT
- SHIFT:
  - mosi = shift_reg[MSB]
  - sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. Decoder samples on the rising edge.
  - At the end of each high phase, shift left one bit and decrement bit_cnt.
  - After the high phase of bit 0, increment burst_cnt.
    - If burst_cnt+1 == BURST_LEN → END.
    - Else if enable & ~fifo_empty → LOAD.
    - Else → END.
- END (1 cycle): xdcs=1, burst_done=1, next state IDLE.
- DREQ is checked only at burst start. It is ignored mid-burst because the decoder guarantees BURST_LEN bytes of space when DREQ is high.
- Boundary cases:
  - enable falls mid-byte: the current byte completes, then END.
  - FIFO empties mid-burst: the current byte completes, then END (short burst).
  - fifo_rd is never asserted while fifo_empty=1.
  - Reset mid-byte: abort; the popped byte is discarded.
- Counters: burst_cnt is clog2(BURST_LEN+1) bits. bit_cnt and div_cnt are sized from their parameters. No wrap-around is possible inside the legal ranges.

## Timing
- Reset values (one edge after reset_n=1):
  - sclk=0, mosi=0, xdcs=1
  - fifo_rd=0, busy=0, burst_done=0
  - state IDLE, all counters 0
- dreq → dreq_s: 2 cycles. The IDLE→LOAD decision is on the 3rd edge after dreq rises (FIFO non-empty, enable high).
- Byte time: 1 + 2·CLK_DIV·DATA_WIDTH cycles. Default is 65 cycles.
- Inside a burst, the LOAD cycle lengthens the SCLK low phase by 1 cycle. xdcs stays low across bytes.
- Burst of N bytes: xdcs low for N·65 cycles, then exactly 1 cycle of END.
- The earliest next burst starts at the cycle after END returns to IDLE.
- All outputs are registered, except fifo_rd, which is a Moore output of LOAD.

## Structure
- Shared package holds:
  - state enum (IDLE, LOAD, SHIFT, END)
  - default constants SDI_CLK_DIV=4, SDI_BURST_LEN=32
- One sub-module: sync_2ff, a generic 2-flop synchronizer for dreq. It is reusable for other decoder status pins.

## Test plan
- Reset: hold reset_n=1 for 3 cycles with dreq=1 and FIFO non-empty. Required: xdcs=1, sclk=0, fifo_rd=0, busy=0.
- Single byte: FIFO holds 0xA5, dreq=1, enable=1. Required:
  - one fifo_rd pulse
  - mosi on the 8 sclk rising edges = 1,0,1,0,0,1,0,1
  - xdcs low for 65 cycles, then burst_done pulses once
- Burst cap: 40 bytes (0x00..0x27) queued, dreq held high. Required:
  - exactly 32 bytes (0x00..0x1F) sent, then xdcs high and burst_done
  - next burst starts with 0x20
- DREQ gate: dreq=0 with 10 bytes queued for 500 cycles. Required: no fifo_rd, xdcs=1. Raising dreq starts LOAD 3 cycles later.
- Short burst: only 3 bytes queued. Required: 3 bytes sent, END immediately after the third, fifo_rd never asserted while empty.
- Reset mid-byte: assert reset_n during bit 4 of byte 0x3C. Required: next edge gives xdcs=1, sclk=0, IDLE. After release, a transfer restarts with the next FIFO byte.

Source files
------------

// File: rtl/mp3_sdi_feeder_pkg.sv
// mp3_sdi_feeder_pkg: shared state encoding and default SDI timing constants
package mp3_sdi_feeder_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, END} state_t;
  localparam int SDI_CLK_DIV = 4;
  localparam int SDI_BURST_LEN = 32;
endpackage

// File: rtl/mp3_sdi_feeder_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous status pins
module sync_2ff #(
  parameter int WIDTH = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q <= '0;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/mp3_sdi_feeder.sv
// mp3_sdi_feeder: pops FIFO bytes and shifts them MSB-first into the decoder SDI port in DREQ-gated bursts
module mp3_sdi_feeder
  import mp3_sdi_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV = SDI_CLK_DIV,
  parameter int BURST_LEN = SDI_BURST_LEN
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  input  logic                  dreq,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  xdcs,
  output logic                  busy,
  output logic                  burst_done
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] burst_cnt;
  logic dreq_s, phase_end, byte_end, go, stop;
  sync_2ff #(.WIDTH(1)) u_sync (.clk(clk), .rst(reset_n), .d(dreq), .q(dreq_s));
  assign phase_end = div_cnt == DW'(CLK_DIV - 1);
  assign byte_end = state == SHIFT && phase_end && sclk && bit_cnt == '0;
  assign go = enable && dreq_s && !fifo_empty;
  assign stop = burst_cnt + 1'b1 == CW'(BURST_LEN) || !enable || fifo_empty;
  assign fifo_rd = state == LOAD;
  assign mosi = shift_reg[DATA_WIDTH-1];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? LOAD : IDLE;
      LOAD:    state_n = SHIFT;
      SHIFT:   state_n = !byte_end ? SHIFT : stop ? END : LOAD;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= IDLE;
      shift_reg <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      burst_cnt <= '0;
      sclk <= 1'b0;
      xdcs <= 1'b1;
      busy <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state <= state_n;
      xdcs <= !(state_n inside {LOAD, SHIFT});
      busy <= state_n != IDLE;
      burst_done <= state_n == END;
      if (state == IDLE) burst_cnt <= '0;
      if (state == LOAD) begin
        shift_reg <= fifo_rdata;
        bit_cnt <= BW'(DATA_WIDTH - 1);
        div_cnt <= '0;
      end
      if (state == SHIFT) begin
        div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
        if (phase_end) sclk <= ~sclk;
        if (phase_end && sclk) shift_reg <= shift_reg << 1;
        if (phase_end && sclk && !byte_end) bit_cnt <= bit_cnt - 1'b1;
        if (byte_end) burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end
endmodule
